// File: rtl/mp_cond_subtract_if.sv
// Controller-side handshake and operand/result bus for the conditional-subtract reduction stage.
`timescale 1ns/1ps
interface mp_cond_subtract_if #(
  parameter int N = 1024
);
  logic         start;
  logic [N+2:0] in_x;
  logic [N-1:0] in_m;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         overflow;

  modport master (output start, in_x, in_m, input busy, done, result, overflow);
  modport slave  (input start, in_x, in_m, output busy, done, result, overflow);
endinterface

// File: rtl/mp_cond_subtract.sv
// Final x mod M reduction for the Montgomery datapath, built around one pipelined carry-select subtractor.
// Define MP_COND_SUB_LOOP_EN for repeated subtraction (bounded by MAX_ITER, flagged by overflow).
`timescale 1ns/1ps
module mpadder1 #(
  parameter int W   = 1027,
  parameter int BLK = 257
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         subtract,
  output logic [W:0]   result
);
  localparam int NB = (W + 1) / BLK;

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_sub;
  logic [W:0]   w_opA;
  logic [W:0]   w_opB;
  logic [W:0]   w_sum;
  logic [BLK:0] w_sum0;
  logic [BLK:0] w_sum1;
  logic         w_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
    end else begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_sub <= subtract;
    end
  end

  // Each block precomputes both carry-in outcomes; only the select muxes ripple.
  always_comb begin
    w_opA   = {1'b0, r_a};
    w_opB   = r_sub ? ~{1'b0, r_b} : {1'b0, r_b};
    w_sum   = '0;
    w_sum0  = '0;
    w_sum1  = '0;
    w_carry = r_sub;
    for (int k = 0; k < NB; k++) begin
      w_sum0 = {1'b0, w_opA[k*BLK +: BLK]} + {1'b0, w_opB[k*BLK +: BLK]};
      w_sum1 = w_sum0 + {{BLK{1'b0}}, 1'b1};
      w_sum[k*BLK +: BLK] = w_carry ? w_sum1[BLK-1:0] : w_sum0[BLK-1:0];
      w_carry = w_carry ? w_sum1[BLK] : w_sum0[BLK];
    end
  end

  assign result = w_sum;
endmodule

module mp_cond_subtract #(
  parameter int N        = 1024,
  parameter int MAX_ITER = 16
) (
  input logic               clk,
  input logic               reset,
  mp_cond_subtract_if.slave bus
);
  localparam int XW = N + 3;

  typedef enum logic [1:0] {IDLE, SUB, CHECK} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [XW-1:0] r_x;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_result;
  logic          r_done;
  logic [XW:0]   w_adderRes;
  logic [XW-1:0] w_diff;
  logic          w_borrow;
  logic          w_capture;
  logic          w_finish;
`ifdef MP_COND_SUB_LOOP_EN
  logic [4:0]    r_iter;
  logic          r_overflow;
  logic          w_reload;
  logic          w_hitBound;
`endif

  mpadder1 #(.W(XW), .BLK((XW + 1) / 4)) u_adder (
    .clk      (clk),
    .reset    (reset),
    .in_a     (r_x),
    .in_b     ({3'b000, r_m}),
    .subtract (1'b1),
    .result   (w_adderRes)
  );

  assign w_diff   = w_adderRes[XW-1:0];
  assign w_borrow = w_adderRes[XW];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // A start that coincides with the done pulse is dropped so a held start yields one operation per pulse.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
`ifdef MP_COND_SUB_LOOP_EN
    w_reload    = 1'b0;
    w_hitBound  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start && !r_done) begin
          w_capture   = 1'b1;
          w_nextState = SUB;
        end
      end
      SUB: w_nextState = CHECK;
      CHECK: begin
`ifdef MP_COND_SUB_LOOP_EN
        if (w_borrow) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end else if (r_iter == 5'(MAX_ITER - 1)) begin
          w_finish    = 1'b1;
          w_hitBound  = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_reload    = 1'b1;
          w_nextState = SUB;
        end
`else
        w_finish    = 1'b1;
        w_nextState = IDLE;
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= '0;
      r_m      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
`ifdef MP_COND_SUB_LOOP_EN
      r_iter     <= '0;
      r_overflow <= 1'b0;
`endif
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_x <= bus.in_x;
        r_m <= bus.in_m;
`ifdef MP_COND_SUB_LOOP_EN
        r_iter     <= '0;
        r_overflow <= 1'b0;
`endif
      end
      // A borrow means x was already below M, so the unmodified operand is the answer.
      if (w_finish) r_result <= w_borrow ? r_x[N-1:0] : w_diff[N-1:0];
`ifdef MP_COND_SUB_LOOP_EN
      if (w_reload) begin
        r_x    <= w_diff;
        r_iter <= r_iter + 5'd1;
      end
      if (w_hitBound) r_overflow <= 1'b1;
`endif
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
`ifdef MP_COND_SUB_LOOP_EN
  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_mp_cond_subtract.sv
// Scoreboard bench for mp_cond_subtract: expectations are queued at start and compared on each done pulse.
`timescale 1ns/1ps
module tb_mp_cond_subtract;
  localparam int N        = 1024;
  localparam int XW       = N + 3;
  localparam int MAX_ITER = 16;

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    int           lat;
    int           startCycle;
  } sbItem_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cycleCnt;
  int   busyCnt;
  int   doneCnt;
  sbItem_t sb[$];

  mp_cond_subtract_if #(.N(N)) bus ();

  mp_cond_subtract #(.N(N), .MAX_ITER(MAX_ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock and a cycle counter used to time each operation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [N-1:0] toWide(input int v);
    logic [N-1:0] w;
    w = '0;
    w[31:0] = v;
    return w;
  endfunction

  function automatic logic [XW-1:0] randomWide();
    logic [XW-1:0] v;
    v = '0;
    for (int i = 0; i < 33; i++) v = {v[XW-33:0], $urandom()};
    return v;
  endfunction

  // Reference reduction: plain subtraction on wide values, repeated in the loop build.
  function automatic sbItem_t predict(input logic [XW-1:0] x, input logic [N-1:0] m);
    sbItem_t       it;
    logic [XW-1:0] v;
    int            k;
    v = x;
    k = 0;
`ifdef MP_COND_SUB_LOOP_EN
    while (v >= {3'b000, m} && k < MAX_ITER) begin
      v = v - {3'b000, m};
      k++;
    end
    it.ovf = (k == MAX_ITER);
    it.lat = it.ovf ? -1 : 3 + 2 * k;
`else
    if (v >= {3'b000, m}) v = v - {3'b000, m};
    k = 0;
    it.ovf = 1'b0;
    it.lat = 3;
`endif
    it.res = v[N-1:0];
    it.startCycle = 0;
    return it;
  endfunction

  task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got(low128)=%h required(low128)=%h", tag, got[127:0], exp[127:0]);
    end
  endtask

  // Monitor: counts busy/done cycles and checks every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    sbItem_t it;
    if (!reset) begin
      if (bus.busy) busyCnt = busyCnt + 1;
      if (bus.done) begin
        doneCnt = doneCnt + 1;
        checkOutput("done_expected", toWide(int'(sb.size() != 0)), toWide(1));
        if (sb.size() != 0) begin
          it = sb.pop_front();
          checkOutput("result", bus.result, it.res);
          checkOutput("overflow", toWide(int'(bus.overflow)), toWide(int'(it.ovf)));
          if (it.lat >= 0) checkOutput("latency", toWide(cycleCnt - it.startCycle), toWide(it.lat));
        end
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", toWide(int'(bus.busy)), toWide(0));
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drained", toWide(sb.size()), toWide(0));
    sb.delete();
  endtask

  task automatic applyStimulus(input logic [XW-1:0] x, input logic [N-1:0] m);
    sbItem_t it;
    logic [XW-1:0] junk;
    waitIdle();
    bus.start = 1'b1;
    bus.in_x  = x;
    bus.in_m  = m;
    it = predict(x, m);
    it.startCycle = cycleCnt;
    sb.push_back(it);
    @(negedge clk);
    junk = randomWide();
    bus.start = 1'b0;
    bus.in_x  = junk;
    bus.in_m  = junk[N-1:0];
    waitDrain(100);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sbItem_t       ref20;
    sbItem_t       it;
    logic [XW-1:0] bigX;
    logic [XW-1:0] rx;
    logic [N-1:0]  rm;
    logic [N-1:0]  rr;
    int            doneBase;
    int            nExp;

    vectors     = 0;
    miscompares = 0;
    busyCnt     = 0;
    doneCnt     = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.in_x    = '0;
    bus.in_m    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", toWide(int'(bus.busy)), toWide(0));
    checkOutput("rst_done", toWide(int'(bus.done)), toWide(0));
    checkOutput("rst_result", bus.result, '0);
    checkOutput("rst_overflow", toWide(int'(bus.overflow)), toWide(0));

    ref20 = predict(XW'(20), N'(13));
    busyCnt = 0;
    applyStimulus(XW'(20), N'(13));
    checkOutput("busy_cycles", toWide(busyCnt), toWide(ref20.lat - 1));

    applyStimulus(XW'(5), N'(13));
    applyStimulus(XW'(13), N'(13));
    applyStimulus(XW'(0), N'(13));

    bigX = '0;
    bigX[N+1] = 1'b1;
    bigX = bigX - XW'(2);
    applyStimulus(bigX, '1);

    applyStimulus(XW'(12345), '0);

    for (int i = 0; i < 4; i++) begin
      rx = randomWide();
      rm = rx[N-1:0];
      rm[N-1] = 1'b1;
      rx = randomWide();
      rr = rx[N-1:0];
      if (rr < rm) rx = {3'b000, rr} + (((i % 2) == 0) ? {3'b000, rm} : '0);
      else         rx = {3'b000, rr};
      applyStimulus(rx, rm);
    end

    // Held start: a new operation may only begin once the previous done pulse has passed.
    waitIdle();
    doneBase = doneCnt;
    nExp = 0;
    for (int c = 0; c < 10; c += ref20.lat + 1) begin
      it = ref20;
      it.startCycle = cycleCnt + c;
      sb.push_back(it);
      nExp++;
    end
    bus.start = 1'b1;
    bus.in_x  = XW'(20);
    bus.in_m  = N'(13);
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    waitDrain(100);
    checkOutput("hold_done_count", toWide(doneCnt - doneBase), toWide(nExp));

    // Reset during CHECK must abandon the operation silently.
    waitIdle();
    doneBase = doneCnt;
    bus.start = 1'b1;
    bus.in_x  = XW'(20);
    bus.in_m  = N'(13);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_in_check", toWide(int'(bus.busy)), toWide(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_result", bus.result, '0);
    checkOutput("abort_busy", toWide(int'(bus.busy)), toWide(0));
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", toWide(doneCnt - doneBase), toWide(0));

`ifdef MP_COND_SUB_LOOP_EN
    applyStimulus(XW'(27), N'(13));
    applyStimulus(XW'(100), N'(7));
    applyStimulus(XW'(17 * 7), N'(7));
    applyStimulus(XW'(20), N'(13));
`else
    applyStimulus(XW'(25), N'(13));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
